// File: rtl/nasti_lite_arb_pkg.sv
// Shared definitions for the NASTI-lite read arbiter.
//   RESP_* : AXI/NASTI response encodings carried on the R channel.
//   idx_width(n) : bits needed to index n items (never less than 1).
package nasti_lite_arb_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // A single-entry structure still needs a one-bit index so that
    // port and register widths stay legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nasti_lite_arb_route_fifo.sv
// Route FIFO: remembers, in AR order, which requester owns each
// outstanding read so R beats can be steered back.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : enqueue requester index (ignored when full)
//   pop, dout  : dequeue / head index (pop ignored when empty)
//   full, empty, count : occupancy status
module nasti_lite_arb_route_fifo
    import nasti_lite_arb_pkg::*;
#(
    parameter  int DEPTH     = 2,
    parameter  int WIDTH     = 1,
    localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [WIDTH-1:0]     din,
    output logic [WIDTH-1:0]     dout,
    output logic                 full,
    output logic                 empty,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int PTR_WIDTH = idx_width(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_WIDTH-1:0]        wr_ptr;
    logic [PTR_WIDTH-1:0]        rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    assign full    = (count == CNT_WIDTH'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/nasti_lite_read_arbiter.sv
// NASTI-lite read arbiter: shares one lite read slave between
// NUM_MASTER requesters. The AR winner is registered (ARREG) and its
// index queued in a route FIFO; R beats, which the slave returns in AR
// order, are steered combinationally to the FIFO head.
// Outstanding reads (FIFO occupancy, including the AR held in ARREG)
// are capped at MAX_TRANSACTION.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   s_ar_* / s_ar_valid : packed per-requester AR, s_ar_ready one-hot
//   s_r_*  / s_r_valid  : R payload broadcast, s_r_valid one-hot
//   s_r_ready           : per-requester R ready
//   m_ar_*              : registered AR towards the slave
//   m_r_*               : R from the slave
// Build option:
//   NASTI_LITE_ARB_RR_EN defined   -> round-robin arbitration
//   NASTI_LITE_ARB_RR_EN undefined -> fixed priority, lowest index wins
module nasti_lite_read_arbiter
    import nasti_lite_arb_pkg::*;
#(
    parameter int NUM_MASTER      = 2,
    parameter int MAX_TRANSACTION = 2,
    parameter int ID_WIDTH        = 1,
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_WIDTH      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    // requester side
    input  logic [NUM_MASTER-1:0][ID_WIDTH-1:0]   s_ar_id,
    input  logic [NUM_MASTER-1:0][ADDR_WIDTH-1:0] s_ar_addr,
    input  logic [NUM_MASTER-1:0][2:0]            s_ar_prot,
    input  logic [NUM_MASTER-1:0][3:0]            s_ar_qos,
    input  logic [NUM_MASTER-1:0][3:0]            s_ar_region,
    input  logic [NUM_MASTER-1:0][USER_WIDTH-1:0] s_ar_user,
    input  logic [NUM_MASTER-1:0]                 s_ar_valid,
    output logic [NUM_MASTER-1:0]                 s_ar_ready,
    output logic [ID_WIDTH-1:0]                   s_r_id,
    output logic [DATA_WIDTH-1:0]                 s_r_data,
    output logic [1:0]                            s_r_resp,
    output logic [USER_WIDTH-1:0]                 s_r_user,
    output logic [NUM_MASTER-1:0]                 s_r_valid,
    input  logic [NUM_MASTER-1:0]                 s_r_ready,
    // slave side
    output logic [ID_WIDTH-1:0]                   m_ar_id,
    output logic [ADDR_WIDTH-1:0]                 m_ar_addr,
    output logic [2:0]                            m_ar_prot,
    output logic [3:0]                            m_ar_qos,
    output logic [3:0]                            m_ar_region,
    output logic [USER_WIDTH-1:0]                 m_ar_user,
    output logic                                  m_ar_valid,
    input  logic                                  m_ar_ready,
    input  logic [ID_WIDTH-1:0]                   m_r_id,
    input  logic [DATA_WIDTH-1:0]                 m_r_data,
    input  logic [1:0]                            m_r_resp,
    input  logic [USER_WIDTH-1:0]                 m_r_user,
    input  logic                                  m_r_valid,
    output logic                                  m_r_ready
);

    localparam int IDX_WIDTH = idx_width(NUM_MASTER);
    localparam int CNT_WIDTH = $clog2(MAX_TRANSACTION + 1);

    localparam logic [0:0] AR_EMPTY = 1'b0;
    localparam logic [0:0] AR_FULL  = 1'b1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [USER_WIDTH-1:0] user;
    } ar_t;

    ar_t [NUM_MASTER-1:0] req_ar;
    ar_t                  ar_q;
    logic [0:0]           ar_state;

    logic                 grant_ok;
    logic                 grant_any;
    logic                 grant;
    logic [IDX_WIDTH-1:0] grant_idx;

    logic                 route_full;
    logic                 route_empty;
    logic [CNT_WIDTH-1:0] route_count;
    logic [IDX_WIDTH-1:0] route_head;
    logic                 r_pop;

    for (genvar i = 0; i < NUM_MASTER; i++) begin : g_req
        assign req_ar[i] = '{id:     s_ar_id[i],
                             addr:   s_ar_addr[i],
                             prot:   s_ar_prot[i],
                             qos:    s_ar_qos[i],
                             region: s_ar_region[i],
                             user:   s_ar_user[i]};
    end

    // ---------------- arbitration ----------------
`ifdef NASTI_LITE_ARB_RR_EN
    // Holds the index with highest priority next, i.e. one past the
    // last grant; reset 0 so requester 0 wins the first contest.
    logic [IDX_WIDTH-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant) begin
            rr_ptr <= (grant_idx == IDX_WIDTH'(NUM_MASTER - 1)) ? '0
                                                                : grant_idx + IDX_WIDTH'(1);
        end
    end
`endif

    always_comb begin
        int k;
        k         = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTER; i++) begin
`ifdef NASTI_LITE_ARB_RR_EN
            k = int'(rr_ptr) + i;
            if (k >= NUM_MASTER) k = k - NUM_MASTER;
`else
            k = i;
`endif
            if (!grant_any && s_ar_valid[k]) begin
                grant_any = 1'b1;
                grant_idx = IDX_WIDTH'(k);
            end
        end
    end

    // ARREG can take a new AR when empty or when its current AR leaves
    // this cycle; credit counts the AR still sitting in ARREG.
    assign grant_ok   = !rst
                     && ((ar_state == AR_EMPTY) || m_ar_ready)
                     && (route_count < CNT_WIDTH'(MAX_TRANSACTION));
    assign grant      = grant_ok && grant_any;
    assign s_ar_ready = grant ? (NUM_MASTER'(1) << grant_idx) : '0;

    // ---------------- AR register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_state <= AR_EMPTY;
            ar_q     <= '0;
        end else if (grant) begin
            ar_state <= AR_FULL;
            ar_q     <= req_ar[grant_idx];
        end else if (m_ar_ready) begin
            ar_state <= AR_EMPTY;
        end
    end

    assign m_ar_valid  = (ar_state == AR_FULL);
    assign m_ar_id     = ar_q.id;
    assign m_ar_addr   = ar_q.addr;
    assign m_ar_prot   = ar_q.prot;
    assign m_ar_qos    = ar_q.qos;
    assign m_ar_region = ar_q.region;
    assign m_ar_user   = ar_q.user;

    // ---------------- route FIFO ----------------
    nasti_lite_arb_route_fifo #(
        .DEPTH (MAX_TRANSACTION),
        .WIDTH (IDX_WIDTH)
    ) u_route_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (grant),
        .pop   (r_pop),
        .din   (grant_idx),
        .dout  (route_head),
        .full  (route_full),
        .empty (route_empty),
        .count (route_count)
    );

    // Credit check above must keep pushes away from a full FIFO.
    always_ff @(posedge clk) begin
        if (!rst && grant) begin
            assert (!route_full);
        end
    end

    // ---------------- R steering ----------------
    // A beat arriving with nothing outstanding is left stalled.
    assign s_r_valid = (m_r_valid && !route_empty) ? (NUM_MASTER'(1) << route_head) : '0;
    assign m_r_ready = !route_empty && s_r_ready[route_head];
    assign r_pop     = m_r_valid && m_r_ready;

    assign s_r_id   = m_r_id;
    assign s_r_data = m_r_data;
    assign s_r_resp = m_r_resp;
    assign s_r_user = m_r_user;

endmodule
